// File: rtl/ram_sized_hs.sv
// Byte-addressed big-endian data RAM with MFA/MOC four-phase handshake
// and a programmable wait-state counter that models slow memory.
//
// Ports:
//   Clk        rising-edge clock
//   Reset      synchronous, active-high; memory contents survive reset
//   Enable     MFA request, held high until MOC is seen
//   ReadWrite  1 = read, 0 = write
//   Size       00 byte, 01 halfword, 10/11 word
//   Address    byte address of the most significant byte
//   DataIn     write data, right-justified (byte [7:0], half [15:0])
//   DataOut    zero-extended read data, valid while MOC = 1
//   MOC        memory operation complete
//   Busy       high in WAIT or DONE
//   AlignErr   (ALIGN_CHECK_EN only) misaligned access, rises/falls with MOC
//
// Optional feature macro: ALIGN_CHECK_EN
module ram_sized_hs #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              ReadWrite,
    input  logic [1:0]        Size,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC,
`ifdef ALIGN_CHECK_EN
    output logic              Busy,
    output logic              AlignErr
`else
    output logic              Busy
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic [31:0]       dout_q, dout_d;
    logic              moc_q, moc_d;
    logic              err_q, err_d;

    logic [7:0]        mem [DEPTH];
    logic [IDX_W-1:0]  idx [4];
    logic [7:0]        wbyte [4];
    logic [7:0]        rbyte [4];
    logic [3:0]        lane_en;
    logic [31:0]       wword;
    logic [31:0]       rdata;
    logic              mis;
    logic              mem_we;

    // Lane i holds byte i of the access (lane 0 = MSB), wrapped at DEPTH.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            logic [31:0] tmp;
            tmp    = (32'(addr_q) + 32'(i)) % 32'(DEPTH);
            idx[i] = IDX_W'(tmp);
        end
    end

    always_comb begin
        lane_en = 4'b1111;
        wword   = din_q;
        unique case (size_q)
            2'b00: begin
                lane_en = 4'b0001;
                wword   = {din_q[7:0], 24'b0};
            end
            2'b01: begin
                lane_en = 4'b0011;
                wword   = {din_q[15:0], 16'b0};
            end
            default: begin
                lane_en = 4'b1111;
                wword   = din_q;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            wbyte[i] = wword[31-8*i -: 8];
            rbyte[i] = mem[idx[i]];
        end
    end

    always_comb begin
        unique case (size_q)
            2'b00:   rdata = {24'b0, rbyte[0]};
            2'b01:   rdata = {16'b0, rbyte[0], rbyte[1]};
            default: rdata = {rbyte[0], rbyte[1], rbyte[2], rbyte[3]};
        endcase
    end

`ifdef ALIGN_CHECK_EN
    assign mis = ((size_q == 2'b01) && addr_q[0]) ||
                 (size_q[1] && (addr_q[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        size_d  = size_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dout_d  = dout_q;
        moc_d   = moc_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (Enable) begin
                    rw_d   = ReadWrite;
                    size_d = Size;
                    addr_d = Address;
                    din_d  = DataIn;
                    cnt_d  = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) state_d = S_ACCESS;
                    else                  state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACCESS: begin
                moc_d   = 1'b1;
                err_d   = mis;
                state_d = S_DONE;
                if (mis)       dout_d = '0;
                else if (rw_q) dout_d = rdata;
            end
            default: begin
                if (!Enable) begin
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Outputs; a reset landing on ACCESS must not commit the write
    always_comb begin
        Busy   = (state_q == S_WAIT) || (state_q == S_DONE);
        mem_we = (state_q == S_ACCESS) && !rw_q && !mis && !Reset;
    end

    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && lane_en[i]) mem[idx[i]] <= wbyte[i];
        end
    end

    assign DataOut = dout_q;
    assign MOC     = moc_q;
`ifdef ALIGN_CHECK_EN
    assign AlignErr = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_ram_sized_hs.sv
// Self-checking bench for ram_sized_hs: vector table plus handshake
// corner sequences, with a scoreboard of expected DataOut at each MOC.
module tb_ram_sized_hs;

    logic        Clk;
    logic        Reset;
    logic        Enable;
    logic        ReadWrite;
    logic [1:0]  Size;
    logic [8:0]  Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        Busy;
`ifdef ALIGN_CHECK_EN
    logic        AlignErr;
`endif

    ram_sized_hs #(
        .ADDR_W(9),
        .DEPTH(512),
        .WAIT_STATES(2)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Enable(Enable),
        .ReadWrite(ReadWrite),
        .Size(Size),
        .Address(Address),
        .DataIn(DataIn),
        .DataOut(DataOut),
        .MOC(MOC),
`ifdef ALIGN_CHECK_EN
        .Busy(Busy),
        .AlignErr(AlignErr)
`else
        .Busy(Busy)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rw;
        logic [1:0]  sz;
        logic [8:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    int          total;
    int          bad;
    logic [31:0] sb[$];
    logic [31:0] last_dout;
    vec_t        vt[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic sb_check(input string nm);
        logic [31:0] e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got MOC with empty scoreboard want entry", nm);
        end else begin
            e = sb.pop_front();
            check(nm, DataOut, e);
        end
    endtask

    task automatic wait_moc(input string nm);
        for (int k = 0; k < 40; k++) begin
            if (MOC) break;
            @(negedge Clk);
        end
        check({nm, "_moc"}, {31'b0, MOC}, 32'd1);
    endtask

    task automatic access(input string nm, input logic rw,
                          input logic [1:0] sz, input logic [8:0] a,
                          input logic [31:0] d, input logic [31:0] exp);
        if (rw) last_dout = exp;
        sb.push_back(last_dout);
        @(negedge Clk);
        Enable    = 1'b1;
        ReadWrite = rw;
        Size      = sz;
        Address   = a;
        DataIn    = d;
        @(negedge Clk);
        wait_moc(nm);
        sb_check(nm);
        Enable = 1'b0;
        @(negedge Clk);
        check({nm, "_moc_fall"}, {31'b0, MOC}, 32'd0);
    endtask

    initial begin
        logic seen;
        total     = 0;
        bad       = 0;
        last_dout = '0;
        Reset     = 1'b1;
        Enable    = 1'b0;
        ReadWrite = 1'b1;
        Size      = 2'b00;
        Address   = '0;
        DataIn    = '0;

        vt.push_back('{1'b0, 2'b00, 9'd4,  32'h0000_0000, 32'h0});
        vt.push_back('{1'b0, 2'b10, 9'd8,  32'h1122_3344, 32'h0});
        vt.push_back('{1'b0, 2'b10, 9'd24, 32'h0000_0000, 32'h0});
        vt.push_back('{1'b1, 2'b00, 9'd9,  32'h0, 32'h0000_0022});
        vt.push_back('{1'b1, 2'b01, 9'd10, 32'h0, 32'h0000_3344});
        vt.push_back('{1'b1, 2'b10, 9'd8,  32'h0, 32'h1122_3344});
        vt.push_back('{1'b1, 2'b11, 9'd8,  32'h0, 32'h1122_3344});
        vt.push_back('{1'b1, 2'b00, 9'd8,  32'h0, 32'h0000_0011});
        vt.push_back('{1'b0, 2'b00, 9'd9,  32'hFFFF_FFEE, 32'h0});
        vt.push_back('{1'b1, 2'b01, 9'd8,  32'h0, 32'h0000_11EE});
`ifndef ALIGN_CHECK_EN
        vt.push_back('{1'b0, 2'b10, 9'd510, 32'hAABB_CCDD, 32'h0});
        vt.push_back('{1'b1, 2'b00, 9'd510, 32'h0, 32'h0000_00AA});
        vt.push_back('{1'b1, 2'b00, 9'd511, 32'h0, 32'h0000_00BB});
        vt.push_back('{1'b1, 2'b00, 9'd0,   32'h0, 32'h0000_00CC});
        vt.push_back('{1'b1, 2'b00, 9'd1,   32'h0, 32'h0000_00DD});
        vt.push_back('{1'b1, 2'b01, 9'd511, 32'h0, 32'h0000_BBCC});
        vt.push_back('{1'b1, 2'b10, 9'd510, 32'h0, 32'hAABB_CCDD});
`endif

        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_moc", {31'b0, MOC}, 32'd0);
        check("rst_busy", {31'b0, Busy}, 32'd0);
        check("rst_dout", DataOut, 32'd0);

        // Latency: Enable seen at edge 0, MOC only after edge 4
        sb.push_back(last_dout);
        Enable    = 1'b1;
        ReadWrite = 1'b0;
        Size      = 2'b10;
        Address   = 9'd8;
        DataIn    = 32'h1122_3344;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            check("lat_moc_low", {31'b0, MOC}, 32'd0);
            if (k == 0) check("lat_busy", {31'b0, Busy}, 32'd1);
        end
        @(negedge Clk);
        check("lat_moc_high", {31'b0, MOC}, 32'd1);
        sb_check("lat_dout");
        Enable = 1'b0;
        @(negedge Clk);
        check("lat_moc_fall", {31'b0, MOC}, 32'd0);

        for (int i = 0; i < vt.size(); i++) begin
            access($sformatf("vec%0d", i), vt[i].rw, vt[i].sz,
                   vt[i].a, vt[i].d, vt[i].exp);
        end

        // Reset during WAIT abandons the write
        @(negedge Clk);
        Enable    = 1'b1;
        ReadWrite = 1'b0;
        Size      = 2'b00;
        Address   = 9'd4;
        DataIn    = 32'h0000_0055;
        @(negedge Clk);
        Reset  = 1'b1;
        Enable = 1'b0;
        @(negedge Clk);
        Reset     = 1'b0;
        last_dout = '0;
        check("rstmid_busy", {31'b0, Busy}, 32'd0);
        check("rstmid_dout", DataOut, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (MOC) seen = 1'b1;
            @(negedge Clk);
        end
        check("rstmid_no_moc", {31'b0, seen}, 32'd0);
        access("rstmid_rd", 1'b1, 2'b00, 9'd4, 32'h0, 32'h0000_0000);

        // Held Enable and inputs changed after capture
        sb.push_back(last_dout);
        @(negedge Clk);
        Enable    = 1'b1;
        ReadWrite = 1'b0;
        Size      = 2'b10;
        Address   = 9'd20;
        DataIn    = 32'hCAFE_F00D;
        @(negedge Clk);
        Address   = 9'd24;
        DataIn    = 32'h1234_5678;
        Size      = 2'b00;
        ReadWrite = 1'b1;
        wait_moc("hold");
        sb_check("hold_dout");
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            check("hold_moc", {31'b0, MOC}, 32'd1);
        end
        Enable = 1'b0;
        @(negedge Clk);
        check("hold_moc_fall", {31'b0, MOC}, 32'd0);
        access("hold_rd20", 1'b1, 2'b10, 9'd20, 32'h0, 32'hCAFE_F00D);
        access("hold_rd24", 1'b1, 2'b10, 9'd24, 32'h0, 32'h0000_0000);

        // Enable dropped during WAIT: write commits, one-cycle MOC
        sb.push_back(last_dout);
        @(negedge Clk);
        Enable    = 1'b1;
        ReadWrite = 1'b0;
        Size      = 2'b00;
        Address   = 9'd30;
        DataIn    = 32'h0000_0077;
        @(negedge Clk);
        Enable = 1'b0;
        wait_moc("drop");
        sb_check("drop_dout");
        @(negedge Clk);
        check("drop_moc_1cyc", {31'b0, MOC}, 32'd0);
        access("drop_rd", 1'b1, 2'b00, 9'd30, 32'h0, 32'h0000_0077);

`ifdef ALIGN_CHECK_EN
        access("al_pre", 1'b0, 2'b00, 9'd2, 32'h0000_005A, 32'h0);
        sb.push_back(32'h0);
        @(negedge Clk);
        Enable    = 1'b1;
        ReadWrite = 1'b0;
        Size      = 2'b10;
        Address   = 9'd2;
        DataIn    = 32'hDEAD_BEEF;
        @(negedge Clk);
        wait_moc("al");
        check("al_err", {31'b0, AlignErr}, 32'd1);
        sb_check("al_dout");
        Enable = 1'b0;
        @(negedge Clk);
        check("al_err_fall", {31'b0, AlignErr}, 32'd0);
        last_dout = '0;
        access("al_rd", 1'b1, 2'b00, 9'd2, 32'h0, 32'h0000_005A);
`endif

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
